// File: rtl/mem_stage_ctrl_if.sv
// DataMem bus between the memory-stage controller and the data memory.
// master: drives address, write data, read/write enables and the error flag; receives read data.
// slave:  the data memory side.
interface mem_stage_ctrl_if #(
  parameter int N = 64
);
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic         dmem_err;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write, dmem_err,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write, dmem_err,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Y86-64 memory-stage front end: E->M pipeline register, DataMem access decode,
// bounds check, loaded value / stage status to write-back, sticky exception lock.
// Ports: clk/reset (sync, active-high); i_M_stall/i_M_bubble pipeline control;
// i_e_* execute-stage results; dmem = DataMem bus; o_M_* registered copies,
// o_m_valM loaded value, o_m_stat final status, o_exc_lock sticky fault flag.
module mem_stage_ctrl #(
  parameter int N         = 64,
  parameter int MEM_BYTES = 16384
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_M_stall,
  input  logic             i_M_bubble,
  input  logic [2:0]       i_e_stat,
  input  logic [3:0]       i_e_icode,
  input  logic             i_e_Cnd,
  input  logic [N-1:0]     i_e_valE,
  input  logic [N-1:0]     i_e_valA,
  input  logic [3:0]       i_e_dstE,
  input  logic [3:0]       i_e_dstM,
  mem_stage_ctrl_if.master dmem,
  output logic [3:0]       o_M_icode,
  output logic             o_M_Cnd,
  output logic [N-1:0]     o_M_valE,
  output logic [3:0]       o_M_dstE,
  output logic [3:0]       o_M_dstM,
  output logic [N-1:0]     o_m_valM,
  output logic [2:0]       o_m_stat,
  output logic             o_exc_lock
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  // Highest legal base address for an 8-byte access.
  localparam logic [N-1:0] ADDR_LIMIT = N'(MEM_BYTES - 8);

  logic [2:0]   r_M_stat;
  logic [3:0]   r_M_icode;
  logic         r_M_Cnd;
  logic [N-1:0] r_M_valE;
  logic [N-1:0] r_M_valA;
  logic [3:0]   r_M_dstE;
  logic [3:0]   r_M_dstM;
  logic         r_exc_lock;

  logic         w_rd;
  logic         w_wr_req;
  logic [N-1:0] w_addr;
  logic         w_err;
  logic [2:0]   w_m_stat;

  // Access decode straight from the pipeline register.
  always_comb begin
    w_rd     = 1'b0;
    w_wr_req = 1'b0;
    w_addr   = '0;
    case (r_M_icode)
      I_RMMOVQ, I_PUSHQ, I_CALL: begin
        w_wr_req = ~r_exc_lock;
        w_addr   = r_M_valE;
      end
      I_MRMOVQ: begin
        w_rd   = 1'b1;
        w_addr = r_M_valE;
      end
      I_POPQ, I_RET: begin
        w_rd   = 1'b1;
        w_addr = r_M_valA;
      end
      default: ;
    endcase
  end

  // Error uses the write request before it is squashed, so a faulting store
  // still reports ADR while never reaching the memory.
  assign w_err    = (w_rd | w_wr_req) & (w_addr > ADDR_LIMIT);
  assign w_m_stat = w_err ? STAT_ADR : r_M_stat;

  assign dmem.mem_addr  = w_addr;
  assign dmem.mem_read  = w_rd;
  assign dmem.mem_write = w_wr_req & ~w_err;
  assign dmem.mem_wdata = (w_wr_req & ~w_err) ? r_M_valA : '0;
  assign dmem.dmem_err  = w_err;

  assign o_m_valM   = (w_rd & ~w_err) ? dmem.mem_rdata : '0;
  assign o_m_stat   = w_m_stat;
  assign o_exc_lock = r_exc_lock;
  assign o_M_icode  = r_M_icode;
  assign o_M_Cnd    = r_M_Cnd;
  assign o_M_valE   = r_M_valE;
  assign o_M_dstE   = r_M_dstE;
  assign o_M_dstM   = r_M_dstM;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_M_stat   <= STAT_AOK;
      r_M_icode  <= I_NOP;
      r_M_Cnd    <= 1'b0;
      r_M_valE   <= '0;
      r_M_valA   <= '0;
      r_M_dstE   <= R_NONE;
      r_M_dstM   <= R_NONE;
      r_exc_lock <= 1'b0;
    end else begin
      // A bubble always carries AOK, so any non-AOK status here belongs to a
      // real instruction.
      if (w_m_stat != STAT_AOK) begin
        r_exc_lock <= 1'b1;
      end
      // Once locked, keep flushing M regardless of stall requests.
      if (r_exc_lock || i_M_bubble) begin
        r_M_stat  <= STAT_AOK;
        r_M_icode <= I_NOP;
        r_M_Cnd   <= 1'b0;
        r_M_valE  <= '0;
        r_M_valA  <= '0;
        r_M_dstE  <= R_NONE;
        r_M_dstM  <= R_NONE;
      end else if (!i_M_stall) begin
        r_M_stat  <= i_e_stat;
        r_M_icode <= i_e_icode;
        r_M_Cnd   <= i_e_Cnd;
        r_M_valE  <= i_e_valE;
        r_M_valA  <= i_e_valA;
        r_M_dstE  <= i_e_dstE;
        r_M_dstM  <= i_e_dstM;
      end
    end
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage front end of the Y86-64 pipeline. Sits between the execute stage and DataMem.
- Holds the E->M pipeline register.
- Decodes icode into the DataMem address, write data, rEn, wEn and dmem_err.
- Returns valM and the stage status to write-back.
- A sticky exception lock suppresses all memory writes once a faulting instruction reaches M.

Parameters:
N, 64, data/address width
MEM_BYTES, 16384, DataMem size in bytes; legal 8-byte access needs addr <= MEM_BYTES-8

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
M_stall  input  1  hold pipeline register
M_bubble  input  1  inject NOP bubble
e_stat  input  3  status from execute (1 AOK, 2 HLT, 3 ADR, 4 INS)
e_icode  input  4  instruction code from execute
e_Cnd  input  1  condition result
e_valE  input  N  ALU result
e_valA  input  N  valA, or valP for CALL (selected upstream)
e_dstE  input  4  destination E (4'hF = none)
e_dstM  input  4  destination M
mem_rdata  input  N  DataMem outData (combinational read)
mem_addr  output  N  to DataMem inAdd
mem_wdata  output  N  to DataMem inData
mem_read  output  1  to DataMem rEn
mem_write  output  1  to DataMem wEn
dmem_err  output  1  to DataMem dmem_err
M_icode, M_Cnd, M_valE, M_dstE, M_dstM  output  4/1/N/4/4  registered copies to write-back
m_valM  output  N  loaded value
m_stat  output  3  final stage status
exc_lock  output  1  sticky exception flag

Behaviour:
- Register update priority, per posedge clk: reset > exc_lock > M_bubble > M_stall > load.
- Reset and bubble load the same values:
  - M_stat=AOK, M_icode=1 (NOP), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=4'hF.
  - reset also clears exc_lock.
- exc_lock=1: register loads the bubble value every cycle until reset. The faulting instruction has already advanced out of M by then.
- Stall: all M_* hold. A stall held across an exception lock is overridden by the lock.
- Load: M_* <= e_*.
- Read/write decode (combinational from the M_* registers):
  - mem_read = icode in {5 MRMOVQ, B POPQ, 9 RET}.
  - mem_write = icode in {4 RMMOVQ, A PUSHQ, 8 CALL} and not exc_lock.
  - mem_read and mem_write are never both 1.
- Address select: mem_addr = M_valE for {4,5,A,8}; M_valA for {B,9}; 0 otherwise.
- Write data: mem_wdata = M_valA when mem_write, else 0.
- Address check:
  - dmem_err = (mem_read|mem_write) and (mem_addr > MEM_BYTES-8), unsigned N-bit compare.
  - addr = MEM_BYTES-8 is legal; MEM_BYTES-7 is an error.
  - On error, mem_write is forced 0 in the same cycle.
- Loaded value: m_valM = mem_rdata when mem_read and not dmem_err, else 0. Combinational, zero-cycle latency from the register.
- Status: m_stat = ADR if dmem_err, else M_stat.
- Lock set: exc_lock <= 1 at posedge when m_stat != AOK and M_stat was not a bubble. It is set the cycle after the faulting instruction sits in M.
- Timing:
  - Store commits at the DataMem edge while the instruction is in M.
  - Load data valid during the same cycle.
  - One cycle E->M latency.
- Simultaneous reset with a stall/bubble/exception: reset wins, all outputs at reset values next cycle.

Test Plan:
- Reset with all inputs random -> next cycle M_icode=1, M_dstE=M_dstM=F, mem_read=mem_write=0, m_stat=1, exc_lock=0.
- Load e_icode=4, e_valE=0x100, e_valA=0xDEADBEEF, e_stat=1 -> next cycle mem_write=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, dmem_err=0. A follow-up icode=5 at 0x100 returns m_valM=0xDEADBEEF.
- icode=B, e_valA=0x3FF8 -> mem_read=1, mem_addr=0x3FF8, dmem_err=0. Repeat with 0x3FF9 -> dmem_err=1, m_valM=0, m_stat=3, exc_lock=1 the following cycle.
- icode=8, valE=0x3FFF0, valA=0x40 -> dmem_err=1, mem_write=0. Next loaded PUSHQ is replaced by a bubble; memory at 0x3FFF0 is unchanged.
- M_stall=1 for 3 cycles with changing e_* -> M_* constant. M_stall=1 and M_bubble=1 together -> bubble loaded.
- e_stat=2 (HLT) with icode=0 -> m_stat=2, no memory access. exc_lock=1 next cycle; stays 1 until reset=1 clears it.
